data_packer: RTL and testbench

- Downstream stage of the 2-bit data/select decoder.
- Samples the decoder's {d1,d0} result symbol on each qualified clock edge.
- Packs SYMS_PER_WORD symbols LSB-first into one word and buffers whole words in a small FIFO.
- Presents buffered words on a valid/ready interface to the capture/monitor logic.
- The decoder is purely combinational and cannot stall, so the packer has no input back-pressure. Loss is reported through a sticky overflow flag instead.

---
 rtl/data_pkg.sv | 22 ++
 rtl/data_packer_fifo.sv | 62 ++++++
 rtl/data_packer.sv | 129 ++++++++++++
 tb/tb_data_packer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_pkg.sv
// Shared definitions for the data_packer slice.
//   SYM_W       : width of one decoder symbol {d1,d0}
//   sym_t       : one decoder symbol
//   acc_state_t : accumulator FSM states
//   cnt_width() : width of the out_cnt port for a given symbols-per-word
package data_pkg;

  localparam int unsigned SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic {
    ST_EMPTY,
    ST_FILL
  } acc_state_t;

  // out_cnt must hold values 0..syms inclusive
  function automatic int unsigned cnt_width(input int unsigned syms);
    return $clog2(syms) + 1;
  endfunction

endpackage

// File: rtl/data_packer_fifo.sv
// Small synchronous FIFO with count-based full/empty and asynchronous reset.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   push       : write push_data (accepted when not full, or when a pop
//                happens in the same cycle)
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (raw storage, only meaningful when !empty)
//   empty/full : occupancy flags derived from the count register
module data_packer_fifo
  import data_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/data_packer.sv
// Packs 2-bit decoder symbols {d1,d0} LSB-first into words and buffers them
// in a FIFO presented on a valid/ready interface. No input back-pressure:
// words arriving while the FIFO is full are dropped and flagged.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   in_valid, d1, d0   : symbol input, sampled when in_valid=1
//   flush              : push the partial word now, zero-padded
//   out_valid/out_ready: output handshake, pop when both high
//   out_word, out_cnt  : head word and its valid symbol count (0 when idle)
//   overflow           : sticky, a word has been dropped
//   out_par            : even parity of out_word (only with
//                        DATA_PACKER_PARITY_EN defined)
module data_packer
  import data_pkg::*;
#(
  parameter int unsigned SYMS_PER_WORD = 4,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  input  logic                                   d1,
  input  logic                                   d0,
  input  logic                                   flush,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SYM_W*SYMS_PER_WORD-1:0]         out_word,
  output logic [cnt_width(SYMS_PER_WORD)-1:0]    out_cnt,
  output logic                                   overflow
`ifdef DATA_PACKER_PARITY_EN
  ,
  output logic                                   out_par
`endif
);

  localparam int unsigned WORD_W = SYM_W * SYMS_PER_WORD;
  localparam int unsigned CNT_W  = cnt_width(SYMS_PER_WORD);
  localparam int unsigned IDX_W  = $clog2(SYMS_PER_WORD);
`ifdef DATA_PACKER_PARITY_EN
  localparam int unsigned ENTRY_W = WORD_W + CNT_W + 1;
`else
  localparam int unsigned ENTRY_W = WORD_W + CNT_W;
`endif

  acc_state_t         state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [WORD_W-1:0]  acc, acc_nx;
  logic [WORD_W-1:0]  word_in;
  logic [CNT_W-1:0]   cnt_in;
  logic               complete;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] entry_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      idx      <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      acc      <= acc_nx;
      overflow <= overflow | (push & full & ~pop);
    end
  end

  always_comb begin
    // current symbol is merged first so a same-cycle flush includes it
    word_in = acc;
    if (in_valid) word_in[idx*SYM_W +: SYM_W] = sym_t'({d1, d0});
    complete = in_valid && (idx == IDX_W'(SYMS_PER_WORD - 1));
    push     = complete || (flush && ((state == ST_FILL) || in_valid));
    cnt_in   = complete ? CNT_W'(SYMS_PER_WORD) : (CNT_W'(idx) + CNT_W'(in_valid));

    state_nx = state;
    idx_nx   = idx;
    acc_nx   = acc;
    // accumulator restarts on every push, even a dropped one
    if (push) begin
      state_nx = ST_EMPTY;
      idx_nx   = '0;
      acc_nx   = '0;
    end else if (in_valid) begin
      state_nx = ST_FILL;
      idx_nx   = idx + IDX_W'(1);
      acc_nx   = word_in;
    end
  end

`ifdef DATA_PACKER_PARITY_EN
  assign entry_in = {^word_in, cnt_in, word_in};
`else
  assign entry_in = {cnt_in, word_in};
`endif

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  data_packer_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry_in),
    .pop       (pop),
    .head      (entry_out),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    out_word = '0;
    out_cnt  = '0;
`ifdef DATA_PACKER_PARITY_EN
    out_par  = 1'b0;
    if (!empty) {out_par, out_cnt, out_word} = entry_out;
`else
    if (!empty) {out_cnt, out_word} = entry_out;
`endif
  end

endmodule

// File: tb/tb_data_packer.sv
module tb_data_packer;

  localparam int unsigned SPW   = 4;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       d1 = 1'b0;
  logic       d0 = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_word;
  logic [2:0] out_cnt;
  logic       overflow;
`ifdef DATA_PACKER_PARITY_EN
  logic       out_par;
`endif

  data_packer #(
    .SYMS_PER_WORD (SPW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .d1        (d1),
    .d0        (d0),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_cnt   (out_cnt),
    .overflow  (overflow)
`ifdef DATA_PACKER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    logic [2:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int         m_idx = 0;
  logic [7:0] m_acc = '0;
  int         m_cnt = 0;

  task automatic model_reset();
    m_idx = 0;
    m_acc = '0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // drive one clock cycle; model predicts the pushed word before the edge
  task automatic cycle(input bit v, input bit [1:0] sym, input bit fl, input bit rdy);
    int  cnt0;
    bit  pop_m;
    bit  push_m;
    exp_t e;
    in_valid  = v;
    {d1, d0}  = sym;
    flush     = fl;
    out_ready = rdy;
    cnt0  = m_cnt;
    pop_m = rdy && (m_cnt > 0);
    if (v) begin
      m_acc[m_idx*2 +: 2] = sym;
      m_idx++;
    end
    push_m = (m_idx == SPW) || (fl && m_idx > 0);
    if (pop_m) begin
      void'(exp_q.pop_front());
      m_cnt--;
    end
    if (push_m) begin
      if (cnt0 < DEPTH || pop_m) begin
        e.w = m_acc;
        e.c = 3'(m_idx);
        exp_q.push_back(e);
        m_cnt++;
      end
      m_idx = 0;
      m_acc = '0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_word !== 8'h00) begin bad++; $display("FAIL rst_word got=%h exp=00", out_word); end
    total++; if (out_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", out_cnt); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    do_reset();
  endtask

  task automatic test_full_word();
    do_reset();
    cycle(1, 2'b01, 0, 1);
    cycle(1, 2'b10, 0, 1);
    cycle(1, 2'b11, 0, 1);
    cycle(1, 2'b00, 0, 1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL w1_valid got=%b exp=1", out_valid); end
    total++; if (out_word !== 8'h39) begin bad++; $display("FAIL w1_word got=%h exp=39", out_word); end
    total++; if (out_cnt !== 3'd4) begin bad++; $display("FAIL w1_cnt got=%0d exp=4", out_cnt); end
    total++; if (exp_q.size() == 0 || out_word !== exp_q[0].w) begin bad++; $display("FAIL w1_sb got=%h exp_q_size=%0d", out_word, exp_q.size()); end
`ifdef DATA_PACKER_PARITY_EN
    total++; if (out_par !== 1'b0) begin bad++; $display("FAIL w1_par got=%b exp=0", out_par); end
`endif
    cycle(0, 2'b00, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL w1_after_valid got=%b exp=0", out_valid); end
    total++; if (out_word !== 8'h00) begin bad++; $display("FAIL w1_idle_word got=%h exp=00", out_word); end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 2'b11, 0, 1);
    cycle(1, 2'b01, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_early_valid got=%b exp=0", out_valid); end
    cycle(0, 2'b00, 1, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fl_valid got=%b exp=1", out_valid); end
    total++; if (out_word !== 8'h07) begin bad++; $display("FAIL fl_word got=%h exp=07", out_word); end
    total++; if (out_cnt !== 3'd2) begin bad++; $display("FAIL fl_cnt got=%0d exp=2", out_cnt); end
`ifdef DATA_PACKER_PARITY_EN
    total++; if (out_par !== 1'b1) begin bad++; $display("FAIL fl_par got=%b exp=1", out_par); end
`endif
    // hold: word stays stable while not ready
    cycle(0, 2'b00, 0, 0);
    total++; if (out_word !== 8'h07 || out_cnt !== 3'd2) begin bad++; $display("FAIL fl_hold got=%h/%0d exp=07/2", out_word, out_cnt); end
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 1, 0);
    cycle(0, 2'b00, 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_empty_flush got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush_last();
    do_reset();
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b01, 1, 0);
    cycle(0, 2'b00, 0, 0);
    total++; if (out_word !== 8'h6A || out_cnt !== 3'd4) begin bad++; $display("FAIL fl4_word got=%h/%0d exp=6a/4", out_word, out_cnt); end
    cycle(0, 2'b00, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl4_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    bit [1:0] s;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s = 2'($urandom_range(0, 3));
      cycle(1, s, 0, 0);
      if (i == 18) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ov_early got=%b exp=0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_set got=%b exp=1", overflow); end
    total++; if (exp_q.size() != 4) begin bad++; $display("FAIL ov_model_size got=%0d exp=4", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || out_word !== exp_q[0].w || out_cnt !== exp_q[0].c) begin
        bad++; $display("FAIL ov_drain%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_word, out_cnt,
                        exp_q.size() ? exp_q[0].w : 8'h00, exp_q.size() ? exp_q[0].c : 3'd0);
      end
      cycle(0, 2'b00, 0, 1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ov_drained got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_pop();
    bit [1:0] s;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s = 2'($urandom_range(0, 3));
      cycle(1, s, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      s = 2'($urandom_range(0, 3));
      cycle(1, s, 0, (i == 3));
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_ovf got=%b exp=0", overflow); end
    total++; if (exp_q.size() != 4) begin bad++; $display("FAIL fp_model_size got=%0d exp=4", exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || out_word !== exp_q[0].w || out_cnt !== exp_q[0].c) begin
        bad++; $display("FAIL fp_drain%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_word, out_cnt,
                        exp_q.size() ? exp_q[0].w : 8'h00, exp_q.size() ? exp_q[0].c : 3'd0);
      end
      cycle(0, 2'b00, 0, 1);
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b01, 0, 0);
    cycle(1, 2'b01, 0, 0);
    total++; if (out_valid !== 1'b1 || out_word !== 8'hFF) begin bad++; $display("FAIL ar_pre got=%b/%h exp=1/ff", out_valid, out_word); end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0 || out_word !== 8'h00 || out_cnt !== 3'd0) begin
      bad++; $display("FAIL ar_clear got=%b/%h/%0d exp=0/00/0", out_valid, out_word, out_cnt); end
    #2;
    rst = 1'b0;
    cycle(1, 2'b10, 0, 0);
    cycle(1, 2'b00, 0, 0);
    cycle(1, 2'b11, 0, 0);
    cycle(1, 2'b10, 0, 0);
    total++; if (out_word !== 8'hB2 || out_cnt !== 3'd4) begin bad++; $display("FAIL ar_word got=%h/%0d exp=b2/4", out_word, out_cnt); end
    total++; if (exp_q.size() == 0 || out_word !== exp_q[0].w) begin bad++; $display("FAIL ar_sb got=%h exp_q_size=%0d", out_word, exp_q.size()); end
    cycle(0, 2'b00, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_single got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_flush_last();
    test_overflow();
    test_full_pop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
